// File: rtl/snake_pkg.sv
// snake_pkg: shared constants, types and helpers for the snake pixel renderer.
//   - grid geometry (GRID_W x GRID_H cells of 2**CELL_SHIFT pixels)
//   - cell codes written by the game logic
//   - colour constants and the code-to-colour decode
//   - cell address helper (row * 40 + column, built from shifts)
package snake_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;
  localparam int H_ACT      = 640;
  localparam int V_ACT      = 480;
  localparam int CELLS      = GRID_W * GRID_H;
  localparam int ADDR_W     = 11;

  localparam logic [9:0] WALL_COLOR = 10'h200;
  localparam logic [9:0] COLOR_FULL = 10'h3FF;
  localparam logic [9:0] COLOR_OFF  = 10'h000;

  typedef enum logic [1:0] {
    CODE_EMPTY = 2'd0,
    CODE_BODY  = 2'd1,
    CODE_HEAD  = 2'd2,
    CODE_FOOD  = 2'd3
  } cell_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: COLOR_OFF, g: COLOR_OFF, b: COLOR_OFF};
  localparam rgb_t RGB_WALL  = '{r: WALL_COLOR, g: WALL_COLOR, b: WALL_COLOR};

  // Cell address = cy*40 + cx, with the multiply folded into (cy<<5)+(cy<<3).
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] cx,
                                                   input logic [4:0] cy);
    return {1'b0, cy, 5'b0} + {3'b0, cy, 3'b0} + {5'b0, cx};
  endfunction

  function automatic rgb_t code_to_rgb(input logic [1:0] code);
    rgb_t c;
    c = RGB_BLACK;
    case (code)
      CODE_BODY: c.g = COLOR_FULL;
      CODE_HEAD: begin c.r = COLOR_FULL; c.g = COLOR_FULL; end
      CODE_FOOD: c.r = COLOR_FULL;
      default:   c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_cell_ram.sv
// snake_cell_ram: simple dual-port cell map, CELLS x 2 bit.
//   iCLK    clock
//   iWe     write enable (port A)
//   iWaddr  write address
//   iWdata  write data
//   iRaddr  read address (port B)
//   oRdata  registered read data; a same-cycle write to iRaddr returns the old value
module snake_cell_ram
  import snake_pkg::*;
(
  input  logic              iCLK,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iWaddr,
  input  logic [1:0]        iWdata,
  input  logic [ADDR_W-1:0] iRaddr,
  output logic [1:0]        oRdata
);

  logic [1:0] mem [0:CELLS-1];

  // Read and write share one edge with non-blocking updates, so the read
  // always sees the contents from before this cycle's write.
  always_ff @(posedge iCLK) begin
    if (iWe) mem[iWaddr] <= iWdata;
    oRdata <= mem[iRaddr];
  end

endmodule

// File: rtl/snake_pixel_renderer.sv
// snake_pixel_renderer: pixel source for the VGA timing controller.
//   iCLK, iRST_N          pixel clock, asynchronous active-low reset
//   iCoord_X/iCoord_Y     registered pixel coordinate from the controller
//   iWr_En/X/Y/Code       single-cycle cell write from the game logic
//   iClear                pulse starting a clear of the whole map
//   oBusy                 high while the clear engine runs (1200 cycles)
//   oFrame_Tick           one-cycle pulse when the coordinate reaches (639,479)
//   oRed/oGreen/oBlue     pixel colour, 3 cycles after the coordinate
// All strobes (iWr_En, iClear) are sampled on a single clock edge; there is
// no back-pressure: a write that arrives while oBusy is high is dropped.
module snake_pixel_renderer
  import snake_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [9:0] iCoord_X,
  input  logic [9:0] iCoord_Y,
  input  logic       iWr_En,
  input  logic [5:0] iWr_X,
  input  logic [4:0] iWr_Y,
  input  logic [1:0] iWr_Code,
  input  logic       iClear,
  output logic       oBusy,
  output logic       oFrame_Tick,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  // ---------------- clear engine / write port ----------------
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0]        ram_wdata;
  logic              wr_in_range;

  assign wr_in_range = (iWr_X < 6'(GRID_W)) && (iWr_Y < 5'(GRID_H));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = cell_addr(iWr_X, iWr_Y);
    ram_wdata = iWr_Code;
    case (state_q)
      ST_IDLE: begin
        // A clear request takes priority over a coincident game write.
        if (iClear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (iWr_En && wr_in_range) begin
          ram_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = 2'(CODE_EMPTY);
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oBusy = (state_q == ST_CLEAR);

  // ---------------- S0: coordinate register ----------------
  logic [5:0] cx, cy;
  logic       in_range, at_end;

  assign cx       = iCoord_X[9:CELL_SHIFT];
  assign cy       = iCoord_Y[9:CELL_SHIFT];
  assign in_range = (iCoord_X < 10'(H_ACT)) && (iCoord_Y < 10'(V_ACT));
  assign at_end   = (iCoord_X == 10'(H_ACT - 1)) && (iCoord_Y == 10'(V_ACT - 1));

  logic              s0_valid, s0_wall, s0_blank, s0_end;
  logic [ADDR_W-1:0] s0_addr;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s0_valid    <= 1'b0;
      s0_wall     <= 1'b0;
      s0_blank    <= 1'b0;
      s0_end      <= 1'b0;
      s0_addr     <= '0;
      oFrame_Tick <= 1'b0;
    end else begin
      s0_valid <= 1'b1;
      s0_wall  <= in_range && ((cx == 6'd0) || (cx == 6'(GRID_W - 1)) ||
                               (cy == 6'd0) || (cy == 6'(GRID_H - 1)));
      // Off-screen pixels and pixels rendered mid-clear show black.
      s0_blank <= !in_range || (state_q == ST_CLEAR);
      s0_end   <= at_end;
      // Keep the RAM read inside the array for off-screen coordinates.
      s0_addr  <= in_range ? cell_addr(cx, cy[4:0]) : '0;
      // Edge-detect on the registered coordinate: the controller holds the
      // last coordinate through blanking, which must not re-trigger.
      oFrame_Tick <= at_end && !(s0_valid && s0_end);
    end
  end

  // ---------------- S1: map read ----------------
  logic [1:0] rd_code;
  logic       s1_valid, s1_wall, s1_blank;

  snake_cell_ram u_ram (
    .iCLK   (iCLK),
    .iWe    (ram_we),
    .iWaddr (ram_waddr),
    .iWdata (ram_wdata),
    .iRaddr (s0_addr),
    .oRdata (rd_code)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_valid <= 1'b0;
      s1_wall  <= 1'b0;
      s1_blank <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      s1_wall  <= s0_wall;
      s1_blank <= s0_blank;
    end
  end

  // ---------------- S2: colour decode ----------------
  rgb_t out_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      out_q <= RGB_BLACK;
    end else if (!s1_valid) begin
      out_q <= RGB_BLACK;
    end else if (s1_wall) begin
      out_q <= RGB_WALL;
    end else if (s1_blank) begin
      out_q <= RGB_BLACK;
    end else begin
      out_q <= code_to_rgb(rd_code);
    end
  end

  assign oRed   = out_q.r;
  assign oGreen = out_q.g;
  assign oBlue  = out_q.b;

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// tb_snake_pixel_renderer: directed sequence with randomized writes and pixel
// sampling, checked against a cell-map model of the picture.
module tb_snake_pixel_renderer;

  // ---------------- clock / reset ----------------
  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [9:0] coord_x = '0, coord_y = '0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [1:0] wr_code = '0;
  logic       clr = 1'b0;
  logic       busy, tick;
  logic [9:0] red, green, blue;

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  snake_pixel_renderer dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iCoord_X    (coord_x),
    .iCoord_Y    (coord_y),
    .iWr_En      (wr_en),
    .iWr_X       (wr_x),
    .iWr_Y       (wr_y),
    .iWr_Code    (wr_code),
    .iClear      (clr),
    .oBusy       (busy),
    .oFrame_Tick (tick),
    .oRed        (red),
    .oGreen      (green),
    .oBlue       (blue)
  );

  // ---------------- reference model ----------------
  // cell_map holds the code of each cell; -1 marks a cell of unknown content.
  int cell_map [0:1199];

  function automatic logic [29:0] model_px(input int x, input int y, input bit clearing);
    int cx, cy;
    if (x >= 640 || y >= 480) return 30'd0;
    cx = x / 16;
    cy = y / 16;
    if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return {10'h200, 10'h200, 10'h200};
    if (clearing) return 30'd0;
    case (cell_map[cy * 40 + cx])
      1:       return {10'h000, 10'h3FF, 10'h000};
      2:       return {10'h3FF, 10'h3FF, 10'h000};
      3:       return {10'h3FF, 10'h000, 10'h000};
      default: return 30'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [29:0] rgb;
    int          due;
    int          x;
    int          y;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic service_q();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check($sformatf("px(%0d,%0d)", e.x, e.y), {2'b0, red, green, blue}, {2'b0, e.rgb});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge iCLK);
    service_q();
  endtask

  task automatic push_px(input int x, input int y, input bit clearing);
    step();
    coord_x = 10'(x);
    coord_y = 10'(y);
    exp_q.push_back('{rgb: model_px(x, y, clearing), due: cyc + 3, x: x, y: y});
  endtask

  task automatic drain();
    repeat (5) step();
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic cell_write(input int x, input int y, input int code);
    step();
    wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_code = 2'(code);
    step();
    wr_en = 1'b0;
    if (x < 40 && y < 30) cell_map[y * 40 + x] = code;
  endtask

  task automatic random_writes(input int n);
    for (int i = 0; i < n; i++)
      cell_write($urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 3));
  endtask

  task automatic scan();
    for (int i = 0; i < 1200; i++)
      if (cell_map[i] >= 0)
        push_px((i % 40) * 16 + $urandom_range(0, 15), (i / 40) * 16 + $urandom_range(0, 15), 1'b0);
    for (int i = 0; i < 20; i++) begin
      push_px($urandom_range(640, 1023), $urandom_range(0, 1023), 1'b0);
      push_px($urandom_range(0, 639), $urandom_range(480, 1023), 1'b0);
    end
    drain();
  endtask

  // Issues iClear (optionally with a coincident write), injects a write, a
  // repeated clear and pixel reads while busy, and optionally resets mid-way.
  task automatic clear_seq(input bit with_wr, input bit rst_mid, output int n);
    int px, py;
    step();
    clr = 1'b1;
    wr_en = with_wr; wr_x = 6'd10; wr_y = 5'd10; wr_code = 2'd3;
    n = 0;
    for (int t = 0; t < 3000; t++) begin
      step();
      clr = 1'b0;
      wr_en = 1'b0;
      if (busy) n++;
      else break;
      if (t == 300) begin wr_en = 1'b1; wr_x = 6'd3; wr_y = 5'd3; wr_code = 2'd1; end
      if (t == 500) clr = 1'b1;
      if (t >= 400 && t < 450) begin
        if (t % 2 == 1) begin px = 8; py = 16 * ((t % 28) + 1) + 2; end
        else begin px = 16 * ((t % 38) + 1) + 3; py = 16 * ((t % 28) + 1) + 5; end
        coord_x = 10'(px);
        coord_y = 10'(py);
        exp_q.push_back('{rgb: model_px(px, py, 1'b1), due: cyc + 3, x: px, y: py});
      end
      if (rst_mid && t == 600) begin
        #2 iRST_N = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rgb", {2'b0, red, green, blue}, 0);
        exp_q.delete();
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  int n, pulses;

  initial begin
    for (int i = 0; i < 1200; i++) cell_map[i] = -1;
    iRST_N = 1'b1;
    #1 iRST_N = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;

    // First clear: exact duration, injected write must be dropped.
    clear_seq(1'b0, 1'b0, n);
    check("clear_len", n, 1200);
    for (int i = 0; i < 1200; i++) cell_map[i] = 0;
    drain();
    scan();
    push_px(50, 50, 1'b0);
    drain();

    // Head cell at (5,7) covers pixels 80..95 x 112..127.
    cell_write(5, 7, 2);
    for (int y = 112; y < 128; y += 5)
      for (int x = 80; x < 96; x += 5) push_px(x, y, 1'b0);
    push_px(95, 127, 1'b0);
    push_px(96, 112, 1'b0);
    drain();

    // Food under the right wall stays hidden.
    cell_write(39, 10, 3);
    push_px(630, 170, 1'b0);
    drain();

    random_writes(300);
    scan();

    // Clear requested together with a write.
    clear_seq(1'b1, 1'b0, n);
    check("clear_len2", n, 1200);
    for (int i = 0; i < 1200; i++) cell_map[i] = 0;
    drain();
    random_writes(300);
    scan();

    // Frame tick: one pulse per arrival at (639,479).
    step(); coord_x = 10'd0; coord_y = 10'd0;
    repeat (3) step();
    coord_x = 10'd639; coord_y = 10'd479;
    pulses = 0;
    repeat (1000) begin step(); if (tick) pulses++; end
    check("tick_hold", pulses, 1);
    coord_x = 10'd0; coord_y = 10'd0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick) pulses++;
      coord_x = 10'(i * 60); coord_y = 10'(i * 40);
    end
    coord_x = 10'd639; coord_y = 10'd479;
    repeat (20) begin step(); if (tick) pulses++; end
    check("tick_second", pulses, 1);

    // Reset at clear cycle 600: partial clear, no further writes afterward.
    clear_seq(1'b0, 1'b1, n);
    for (int i = 0; i < 595; i++) cell_map[i] = 0;
    for (int i = 595; i < 606; i++) cell_map[i] = -1;
    pulses = 0;
    repeat (50) begin step(); if (busy) pulses++; end
    check("busy_after_rst", pulses, 0);
    scan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_pixel_renderer.md
Name: snake_pixel_renderer

Overview:
Upstream pixel source for the VGA timing controller. It receives the controller's registered pixel coordinates and returns 10-bit R/G/B for that pixel. The picture comes from an internal 40x30 cell map; each cell is 16x16 px and holds a 2-bit code written by the game logic. The block also provides a bulk-clear engine and a once-per-frame tick that the game logic uses to step its state.

Parameters:
GRID_W, 40, cells per row
GRID_H, 30, cells per column
CELL_SHIFT, 4, log2 of cell size in pixels (16 px)
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
WALL_COLOR, 10'h200, value driven on R, G and B for the border ring

Ports:
iCLK  in  1  pixel clock, same as VGA controller
iRST_N  in  1  asynchronous active-low reset
iCoord_X  in  10  pixel X from controller, 0..639
iCoord_Y  in  10  pixel Y from controller, 0..479
iWr_En  in  1  cell write strobe, single cycle
iWr_X  in  6  cell column, 0..39
iWr_Y  in  5  cell row, 0..29
iWr_Code  in  2  0 empty, 1 body, 2 head, 3 food
iClear  in  1  pulse; starts a clear of the whole map
oBusy  out  1  high while clear is running
oFrame_Tick  out  1  one-cycle pulse at end of active frame
oRed  out  10  pixel red
oGreen  out  10  pixel green
oBlue  out  10  pixel blue

Behaviour:
- Reset (async, iRST_N low): all outputs 0; FSM goes to IDLE; pipeline valid bits cleared.
- Map contents are not reset. The integration sequence issues iClear after reset.
- Map storage: 1200 x 2-bit dual-port RAM. Port A is the write port (game logic or clear engine). Port B is a synchronous read for rendering.
- Pipeline, fixed latency 3 cycles from coordinate to colour:
  - S0: register coords; cx = X>>CELL_SHIFT, cy = Y>>CELL_SHIFT; addr = cy*40 + cx (11 bits, computed as (cy<<5)+(cy<<3)+cx).
  - S0: flag wall when cx==0, cx==39, cy==0 or cy==29.
  - S1: RAM read, with the wall flag delayed alongside.
  - S2: colour decode, registered onto the outputs.
- Colour decode:
  - wall: R=G=B=WALL_COLOR, overrides the map code.
  - code 0: 0/0/0.
  - code 1: G=3FF.
  - code 2: R=3FF, G=3FF.
  - code 3: R=3FF.
- Coordinates outside the active range (X>=H_ACT or Y>=V_ACT): output black.
- Write/read collision on the same address: the read returns the old data. A new value is visible from the next frame at the latest.
- FSM states:
  - IDLE: iClear -> CLEAR, cnt=0, oBusy=1.
  - CLEAR: write code 0 at addr cnt each cycle, cnt++. When cnt==1199, write and go to IDLE with oBusy=0, so a clear takes 1200 cycles.
- During CLEAR:
  - iWr_En is ignored and the write is dropped.
  - iClear is ignored.
  - the render path outputs black except the wall.
- iWr_En together with iClear in IDLE: the clear wins and the write is dropped.
- Out-of-range writes (iWr_X>=40 or iWr_Y>=30) are dropped.
- oFrame_Tick:
  - The controller holds its last coordinate through blanking.
  - Pulse for 1 cycle on the first cycle that the registered S0 coordinate becomes (639,479) after being different.
  - It pulses exactly once per frame; a held coordinate does not re-trigger.
- Reset mid-clear: FSM to IDLE, oBusy=0. The map is partly cleared, and the game logic re-issues iClear.

Decomposition:
- Package snake_pkg:
  - cell code constants EMPTY/BODY/HEAD/FOOD
  - GRID_W, GRID_H, CELL_SHIFT
  - colour constants
- Sub-module snake_cell_ram: simple dual-port 1200x2, sync read, write-first disabled (read-old).
- FSM, address pipeline and decode stay in the top module.

Test Plan:
- Reset then iClear -> oBusy high for exactly 1200 cycles. A full frame scan then gives black interior and 10'h200 on all channels for every pixel with cx in {0,39} or cy in {0,29}.
- Write (5,7,HEAD), then drive coord (80..95,112..127) -> 3 cycles later oRed=3FF, oGreen=3FF, oBlue=0. Coord (96,112) -> black.
- Write (39,10,FOOD), then drive coord (630,170) -> wall colour, not red.
- iWr_En asserted during CLEAR at (3,3,BODY) -> after the clear, pixel (50,50) is black.
- Step coord to (639,479) and hold it 1000 cycles -> oFrame_Tick is a single 1-cycle pulse. Coords restart at (0,0) and return to (639,479) -> a second pulse.
- Pull iRST_N low at clear cycle 600 -> oBusy and the outputs go to 0 immediately (asynchronous). After release, oBusy stays 0 and no further RAM writes occur.
